// File: rtl/bus85_mem.sv
`default_nettype none
// bus85_mem: 8085 multiplexed-bus memory and I/O slave with wait states and INTA vector.
// Revision 1.0 - initial release
module bus85_mem #(
  parameter int         AWIDTH = 10,
  parameter int         WAITS  = 1,
  parameter logic [7:0] INTVEC = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ad_i,
  output logic [7:0] ad_o,
  output logic       ad_oe,
  input  logic [7:0] addrhigh,
  input  logic       ale,
  input  logic       iom_,
  input  logic       rd_,
  input  logic       wr_,
  input  logic       inta_,
  output logic       ready,
  input  logic [7:0] io_in,
  output logic [7:0] io_port,
  output logic [7:0] io_addr,
  output logic       io_strobe
);

  localparam int         c_DEPTH = 2**AWIDTH;
  localparam logic [3:0] c_WAITS = 4'(WAITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAITST = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_INTA   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state, w_next, r_tgt, w_tgt;
  logic [3:0]        r_cnt, w_cnt;
  logic [15:0]       r_addr;
  logic [7:0]        r_dout, r_io_port, r_io_addr;
  logic              r_io_strobe;
  logic              w_start, w_tgt_high;
  logic [AWIDTH-1:0] w_idx;
  logic              w_unused_addr;

  // Zeroed at configuration time only; reset must not disturb the contents.
  logic [7:0] r_mem [c_DEPTH] = '{default: 8'h00};

  assign w_idx         = r_addr[AWIDTH-1:0];
  assign w_unused_addr = ^r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_addr <= 16'h0000;
    else if (ale) r_addr <= {addrhigh, ad_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tgt   <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_tgt   <= w_tgt;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tgt      = r_tgt;
    w_cnt      = r_cnt;
    w_start    = 1'b0;
    w_tgt_high = wr_;
    if (r_tgt == S_INTA)      w_tgt_high = inta_;
    else if (r_tgt == S_READ) w_tgt_high = rd_;

    case (r_state)
      S_IDLE: begin
        if (!ale) begin
          if (!inta_) begin
            w_start = 1'b1;
            w_tgt   = S_INTA;
          end else if (!rd_) begin
            w_start = 1'b1;
            w_tgt   = S_READ;
          end else if (!wr_) begin
            w_start = 1'b1;
            w_tgt   = S_WRITE;
          end
          if (w_start) begin
            w_cnt  = c_WAITS;
            w_next = (c_WAITS != 4'd0) ? S_WAITST : w_tgt;
          end
        end
      end
      S_WAITST: begin
        // A strobe released before the wait completes cancels the access.
        if (!ale && w_tgt_high) begin
          w_next = S_IDLE;
          w_cnt  = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_next = r_tgt;
          w_cnt  = 4'd0;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_READ:  if (!ale && rd_)   w_next = S_IDLE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  if (!ale && wr_)   w_next = S_IDLE;
      S_INTA:  if (!ale && inta_) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout      <= 8'h00;
      r_io_port   <= 8'h00;
      r_io_addr   <= 8'h00;
      r_io_strobe <= 1'b0;
    end else begin
      r_io_strobe <= 1'b0;
      if (w_next == S_READ)      r_dout <= iom_ ? io_in : r_mem[w_idx];
      else if (w_next == S_INTA) r_dout <= INTVEC;
      if (r_state == S_WRITE && iom_) begin
        r_io_port   <= ad_i;
        r_io_addr   <= r_addr[7:0];
        r_io_strobe <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_WRITE && !iom_) r_mem[w_idx] <= ad_i;
  end

  assign ad_o      = r_dout;
  assign ad_oe     = (r_state == S_READ) || (r_state == S_INTA);
  assign ready     = (r_state != S_WAITST);
  assign io_port   = r_io_port;
  assign io_addr   = r_io_addr;
  assign io_strobe = r_io_strobe;

endmodule
`default_nettype wire

// File: tb/tb_bus85_mem.sv
`default_nettype none
// tb_bus85_mem: directed bench driving one bus into a zero-wait and a two-wait instance.
// Revision 1.0 - initial release
module tb_bus85_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ad_i = 8'h00, addrhigh = 8'h00, io_in = 8'h77;
  logic       ale = 1'b0, iom_ = 1'b0, rd_ = 1'b1, wr_ = 1'b1, inta_ = 1'b1;

  logic [7:0] ad_o0, io_port0, io_addr0, ad_o2, io_port2, io_addr2;
  logic       ad_oe0, ready0, io_strobe0, ad_oe2, ready2, io_strobe2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus85_mem #(.AWIDTH(10), .WAITS(0), .INTVEC(8'hFF)) u_dut0 (
    .clk(clk), .rst(rst), .ad_i(ad_i), .ad_o(ad_o0), .ad_oe(ad_oe0),
    .addrhigh(addrhigh), .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_),
    .ready(ready0), .io_in(io_in), .io_port(io_port0), .io_addr(io_addr0),
    .io_strobe(io_strobe0)
  );

  bus85_mem #(.AWIDTH(10), .WAITS(2), .INTVEC(8'hFF)) u_dut2 (
    .clk(clk), .rst(rst), .ad_i(ad_i), .ad_o(ad_o2), .ad_oe(ad_oe2),
    .addrhigh(addrhigh), .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_),
    .ready(ready2), .io_in(io_in), .io_port(io_port2), .io_addr(io_addr2),
    .io_strobe(io_strobe2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic iom);
    ale      = 1'b1;
    addrhigh = a[15:8];
    ad_i     = a[7:0];
    iom_     = iom;
    cyc();
    ale = 1'b0;
  endtask

  // sel: 0 = rd_, 1 = inta_, 2 = rd_ and wr_ together
  task automatic do_rd(input string tag, input logic [15:0] a, input logic iom, input int sel,
                       input logic [7:0] e0, input logic [7:0] e2);
    addr_phase(a, iom);
    ad_i = 8'hEE;
    if (sel == 1) inta_ = 1'b0;
    else begin
      rd_ = 1'b0;
      if (sel == 2) wr_ = 1'b0;
    end
    cyc();
    check({tag, ".oe0"},    16'(ad_oe0), 16'h1);
    check({tag, ".data0"},  16'(ad_o0),  16'(e0));
    check({tag, ".ready0"}, 16'(ready0), 16'h1);
    check({tag, ".wait1"},  16'(ready2), 16'h0);
    cyc();
    check({tag, ".wait2"},  16'(ready2), 16'h0);
    check({tag, ".oe2w"},   16'(ad_oe2), 16'h0);
    cyc();
    check({tag, ".ready2"}, 16'(ready2), 16'h1);
    check({tag, ".oe2"},    16'(ad_oe2), 16'h1);
    check({tag, ".data2"},  16'(ad_o2),  16'(e2));
    cyc();
    rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
    cyc();
    check({tag, ".oeoff"},  16'({ad_oe0, ad_oe2}), 16'h0);
  endtask

  task automatic do_wr(input string tag, input logic [15:0] a, input logic iom,
                       input logic [7:0] d, input int len, input int es0, input int es2);
    int s0 = 0;
    int s2 = 0;
    addr_phase(a, iom);
    ad_i = d;
    wr_  = 1'b0;
    for (int i = 0; i < len + 2; i++) begin
      if (i == len) wr_ = 1'b1;
      cyc();
      s0 += int'(io_strobe0);
      s2 += int'(io_strobe2);
      check({tag, ".oe"},     16'({ad_oe0, ad_oe2}), 16'h0);
      check({tag, ".ready0"}, 16'(ready0), 16'h1);
      // a second store after this point would leave the wrong byte behind
      if (i == 3) ad_i = ~d;
    end
    check({tag, ".strb0"}, 16'(s0), 16'(es0));
    check({tag, ".strb2"}, 16'(s2), 16'(es2));
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    check("rst.oe",     16'({ad_oe0, ad_oe2}), 16'h0);
    check("rst.ad_o",   16'({ad_o0, ad_o2}), 16'h0000);
    check("rst.ready",  16'({ready0, ready2}), 16'h3);
    check("rst.ioport", 16'({io_port0, io_port2}), 16'h0000);
    check("rst.ioaddr", 16'({io_addr0, io_addr2}), 16'h0000);
    check("rst.iostrb", 16'({io_strobe0, io_strobe2}), 16'h0);
    rst = 1'b0;
    cyc();

    do_rd("blank", 16'h0040, 1'b0, 0, 8'h00, 8'h00);
    do_wr("w12",   16'h0012, 1'b0, 8'hA5, 5, 0, 0);
    do_rd("r12",   16'h0012, 1'b0, 0, 8'hA5, 8'hA5);

    do_wr("iow",   16'h2020, 1'b1, 8'h3C, 5, 1, 1);
    check("iow.port0", 16'(io_port0), 16'h003C);
    check("iow.addr0", 16'(io_addr0), 16'h0020);
    check("iow.port2", 16'(io_port2), 16'h003C);
    check("iow.addr2", 16'(io_addr2), 16'h0020);
    do_rd("r2020", 16'h2020, 1'b0, 0, 8'h00, 8'h00);

    do_wr("alias", 16'h0400, 1'b0, 8'h5A, 5, 0, 0);
    do_rd("r0000", 16'h0000, 1'b0, 0, 8'h5A, 8'h5A);

    do_rd("inta",  16'h0000, 1'b0, 1, 8'hFF, 8'hFF);
    do_rd("rdwr",  16'h0012, 1'b0, 2, 8'hA5, 8'hA5);
    do_rd("r12b",  16'h0012, 1'b0, 0, 8'hA5, 8'hA5);
    do_rd("ior",   16'h0033, 1'b1, 0, 8'h77, 8'h77);

    do_wr("abort", 16'h0100, 1'b0, 8'hC3, 2, 0, 0);
    check("abort.ready2", 16'(ready2), 16'h1);
    do_rd("rabort", 16'h0100, 1'b0, 0, 8'hC3, 8'h00);

    addr_phase(16'h0012, 1'b0);
    rd_ = 1'b0;
    cyc();
    check("mid.oe0pre", 16'(ad_oe0), 16'h1);
    rst = 1'b1;
    #1;
    check("mid.oe",     16'({ad_oe0, ad_oe2}), 16'h0);
    check("mid.ad_o",   16'({ad_o0, ad_o2}), 16'h0000);
    check("mid.ready",  16'({ready0, ready2}), 16'h3);
    check("mid.ioport", 16'({io_port0, io_port2}), 16'h0000);
    check("mid.ioaddr", 16'({io_addr0, io_addr2}), 16'h0000);
    cyc();
    rd_ = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("mid.idle", 16'({ad_oe0, ad_oe2, ready0, ready2}), 16'h3);
    do_rd("post", 16'h0012, 1'b0, 0, 8'hA5, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus85_mem.md
BUS85_MEM -- requirements
Module: bus85_mem

Interface
REQ-001 Parameter AWIDTH, default 10, memory address bits (2**AWIDTH bytes).
REQ-002 Parameter WAITS, default 1, wait-state clocks inserted per access (0..15).
REQ-003 Parameter INTVEC, default 8'hFF, opcode returned on interrupt acknowledge (RST 7).
REQ-004 clk  input  1  single system clock; all state changes on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ad_i  input  8  multiplexed address/data bus as driven by the 8085 core.
REQ-007 ad_o  output  8  data driven back onto the multiplexed bus.
REQ-008 ad_oe  output  1  drive enable for ad_o (tri-state control, 1 = drive).
REQ-009 addrhigh  input  8  upper address byte from the core.
REQ-010 ale  input  1  address latch enable, active-high.
REQ-011 iom_  input  1  1 = I/O cycle, 0 = memory cycle.
REQ-012 rd_, wr_, inta_  input  1 each  active-low read, write, interrupt-acknowledge strobes.
REQ-013 ready  output  1  wait-state request to the core (0 = insert wait).
REQ-014 io_in  input  8  data returned on I/O read.
REQ-015 io_port  output  8  last byte written by an I/O write.
REQ-016 io_addr  output  8  port number of last I/O write.
REQ-017 io_strobe  output  1  one-clock pulse per I/O write.

Function
REQ-018 Address latch: every posedge with ale=1 SHALL capture {addrhigh, ad_i}; value held while ale=0.
REQ-019 Memory index SHALL be latched address[AWIDTH-1:0]; higher bits ignored (aliasing, no error).
REQ-020 FSM states IDLE, WAITST, READ, WRITE, INTA, DONE; strobes sampled only when ale=0.
REQ-021 IDLE: strobe priority inta_ > rd_ > wr_; on a sampled-low strobe, load wait counter with WAITS, go WAITST if WAITS>0 else directly to READ/WRITE/INTA.
REQ-022 WAITST: ready=0; counter decrements each clock; at 1 go to target state; ready=1 in every other state.
REQ-023 READ: ad_o = memory byte (iom_=0) or io_in (iom_=1), registered; ad_oe=1 from first READ clock until the posedge rd_ samples high, then IDLE.
REQ-024 WRITE: on first WRITE clock store ad_i to memory (iom_=0) or to io_port with io_addr = latched low byte and io_strobe=1 for that clock only (iom_=1); go DONE.
REQ-025 DONE: no further writes; return to IDLE when wr_ samples high (exactly one write per wr_ low pulse regardless of length).
REQ-026 INTA: ad_o = INTVEC, ad_oe=1, no memory access; return to IDLE when inta_ samples high.
REQ-027 rd_ and wr_ low together SHALL be treated as read; no memory or port modified.
REQ-028 Strobe rising during WAITST SHALL abort: return to IDLE, ready=1, no write, ad_oe=0.
REQ-029 ad_oe SHALL never be 1 in IDLE, WAITST, WRITE or DONE.
REQ-030 Memory read of an address never written returns 8'h00 (memory zero-initialised at time zero, not by reset).

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, ad_oe=0, ad_o=8'h00, ready=1, io_port=8'h00, io_addr=8'h00, io_strobe=0, latched address 16'h0000, wait counter 0.
REQ-032 Memory contents SHALL be unaffected by rst.
REQ-033 rst asserted mid-access SHALL drop ad_oe immediately; after release the block waits in IDLE for a fresh ale/strobe sequence.

Verification
REQ-034 WAITS=0: memory write 8'hA5 to 16'h0012, then read 16'h0012 -> ad_o=8'hA5, ad_oe=1 only while rd_ low, ready constantly 1.
REQ-035 WAITS=2: read 16'h0040 -> ready=0 for exactly 2 clocks after rd_ sampled low, then ad_o valid with ready=1.
REQ-036 I/O write 8'h3C to port 8'h20 -> io_port=8'h3C, io_addr=8'h20, io_strobe high one clock; memory 16'h2020 unchanged (reads 8'h00).
REQ-037 wr_ held low 5 clocks to 16'h0400 with AWIDTH=10 -> single write to index 0; read of 16'h0000 returns same byte (alias).
REQ-038 inta_ low -> ad_o=8'hFF, ad_oe=1; rd_ and wr_ low together -> read data returned, memory unchanged.
REQ-039 rst pulsed during READ with ad_oe=1 -> ad_oe=0 same cycle, all outputs at REQ-031 values, prior memory data still readable.
